// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline register with 2-entry skid buffer, flush and stall counter
module pipe_stage_buf #(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] stall_count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic             main_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [CNT_W-1:0] stall_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = main_valid_q & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
            stall_q      <= '0;
        end else begin
            // Stall counting is independent of flush so squashed stalls stay visible.
            if (main_valid_q && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end

            if (flush_i) begin
                state_q      <= EMPTY;
                main_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            main_q       <= in_data_i;
                            main_valid_q <= 1'b1;
                            state_q      <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_data_i;
                        end else if (in_fire) begin
                            skid_q     <= in_data_i;
                            in_ready_q <= 1'b0;
                            state_q    <= FULL;
                        end else if (out_fire) begin
                            main_valid_q <= 1'b0;
                            state_q      <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            main_q     <= skid_q;
                            in_ready_q <= 1'b1;
                            state_q    <= BUSY;
                        end
                    end
                    default: begin
                        state_q      <= EMPTY;
                        main_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = main_valid_q;
    assign out_data_o    = (BUBBLE_ZERO && !main_valid_q) ? '0 : main_q;
    assign stall_count_o = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed table-driven bench for pipe_stage_buf
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [15:0] stall_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] out_data_b;
    logic [2:0]  stall_b;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf #(.WIDTH(32), .CNT_W(16), .BUBBLE_ZERO(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
        .flush_i(flush),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
        .stall_count_o(stall_a)
    );

    pipe_stage_buf #(.WIDTH(32), .CNT_W(3), .BUBBLE_ZERO(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
        .flush_i(flush),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
        .stall_count_o(stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic [31:0] od;
        logic [31:0] od_stale;
        logic        ir;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic fl, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // in_valid, in_data, flush, out_ready | out_valid, out_data, out_data(stale), in_ready
        vecs[0]  = '{1'b1, 32'h1,  1'b0, 1'b1, 1'b1, 32'h1,  32'h1,  1'b1};
        vecs[1]  = '{1'b1, 32'h2,  1'b0, 1'b1, 1'b1, 32'h2,  32'h2,  1'b1};
        vecs[2]  = '{1'b1, 32'h3,  1'b0, 1'b1, 1'b1, 32'h3,  32'h3,  1'b1};
        vecs[3]  = '{1'b1, 32'h4,  1'b0, 1'b1, 1'b1, 32'h4,  32'h4,  1'b1};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'h4,  1'b1};
        vecs[5]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 32'hA,  32'hA,  1'b1};
        vecs[6]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  32'hA,  1'b0};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hB,  32'hB,  1'b1};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'hB,  1'b1};
        vecs[9]  = '{1'b1, 32'hA,  1'b0, 1'b0, 1'b1, 32'hA,  32'hA,  1'b1};
        vecs[10] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  32'hA,  1'b0};
        vecs[11] = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b0, 32'h0,  32'hA,  1'b1};
        vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'hA,  1'b1};
        vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'hA,  1'b1};
        vecs[14] = '{1'b1, 32'h7,  1'b0, 1'b1, 1'b1, 32'h7,  32'h7,  1'b1};
        vecs[15] = '{1'b1, 32'h8,  1'b1, 1'b1, 1'b0, 32'h0,  32'h7,  1'b1};
        vecs[16] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'h7,  1'b1};
        vecs[17] = '{1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h55, 32'h55, 1'b1};
        vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'h55, 1'b1};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("reset out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("reset out_data", {32'd0, out_data_a}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready_a}, 64'd1);
        chk("reset stall_count", {48'd0, stall_a}, 64'd0);
        chk("reset out_data stale variant", {32'd0, out_data_b}, 64'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].ordy);
            step();
            chk($sformatf("v%0d out_valid", i), {63'd0, out_valid_a}, {63'd0, vecs[i].ov});
            chk($sformatf("v%0d out_data", i), {32'd0, out_data_a}, {32'd0, vecs[i].od});
            chk($sformatf("v%0d in_ready", i), {63'd0, in_ready_a}, {63'd0, vecs[i].ir});
            chk($sformatf("v%0d out_valid stale variant", i), {63'd0, out_valid_b}, {63'd0, vecs[i].ov});
            chk($sformatf("v%0d out_data stale variant", i), {32'd0, out_data_b}, {32'd0, vecs[i].od_stale});
        end
        chk("table stall_count", {48'd0, stall_a}, 64'd3);
        chk("table stall_count narrow", {61'd0, stall_b}, 64'd3);

        // Saturation: one held entry, ten stalled cycles, then a stalled flush.
        rst = 1'b1;
        #1;
        chk("mid reset stall_count", {48'd0, stall_a}, 64'd0);
        step();
        rst = 1'b0;
        drive(1'b1, 32'h9, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("sat narrow stall_count", {61'd0, stall_b}, 64'd7);
        chk("sat wide stall_count", {48'd0, stall_a}, 64'd10);
        chk("sat held out_data", {32'd0, out_data_a}, 64'h9);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("sat after flush narrow", {61'd0, stall_b}, 64'd7);
        chk("sat after flush wide", {48'd0, stall_a}, 64'd11);
        chk("sat after flush out_valid", {63'd0, out_valid_a}, 64'd0);
        rst = 1'b1;
        #1;
        chk("sat after rst narrow", {61'd0, stall_b}, 64'd0);
        step();
        rst = 1'b0;

        // Async reset while FULL, asserted between clock edges.
        drive(1'b1, 32'h1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h2, 1'b0, 1'b0);
        step();
        chk("full in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("full stall_count", {48'd0, stall_a}, 64'd1);
        drive(1'b1, 32'h3, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("async out_data", {32'd0, out_data_a}, 64'd0);
        chk("async stall_count", {48'd0, stall_a}, 64'd0);
        chk("async in_ready", {63'd0, in_ready_a}, 64'd1);
        drive(1'b1, 32'h66, 1'b0, 1'b1);
        step();
        chk("no transfer in reset", {63'd0, out_valid_a}, 64'd0);
        #4;
        rst = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("post reset out_valid", {63'd0, out_valid_a}, 64'd1);
        chk("post reset out_data", {32'd0, out_data_a}, 64'h77);
        step();
        chk("post reset drained", {63'd0, out_valid_a}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
